// File: rtl/dmem_pkg.sv
// Shared types and defaults for the handshaked data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dmem_state_t;

    localparam int DMEM_DATA_W = 8;
    localparam int DMEM_ADDR_W = 8;
    localparam int DMEM_DEPTH  = 256;
    localparam int DMEM_CNT_W  = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word storage; contents are never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int IDX_W  = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on reads, so it holds the last read word across writes
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/data_memory_hs.sv
// Data memory with req/ack handshake, configurable wait states, one transaction in flight.
// Optional out-of-range detection with err output under macro DMEM_BOUNDS_CHECK_EN.
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int DATA_W      = DMEM_DATA_W,
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int DEPTH       = DMEM_DEPTH,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DMEM_CNT_W-1:0] WAIT_INIT =
        (WAIT_STATES > 0) ? DMEM_CNT_W'(WAIT_STATES - 1) : '0;

    dmem_state_t           state;
    logic [DMEM_CNT_W-1:0] cnt;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  rd_ok;
    logic [DATA_W-1:0]     arr_rdata;

    logic                  go_done;
    logic                  acc_we;
    logic [ADDR_W-1:0]     acc_addr;
    logic [DATA_W-1:0]     acc_wdata;
    logic                  in_range;
    logic                  arr_en;
    logic                  unused_addr;

    // With no wait states the access happens on the accept edge, so it uses the live inputs
    always_comb begin
        go_done   = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        case (state)
            IDLE: begin
                go_done   = req && (WAIT_STATES == 0);
                acc_we    = we;
                acc_addr  = addr;
                acc_wdata = wdata;
            end
            WAIT:    go_done = (cnt == '0);
            default: go_done = 1'b0;
        endcase
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    assign in_range = ({1'b0, acc_addr} < (ADDR_W + 1)'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    assign arr_en      = go_done && in_range && rst_n;
    assign unused_addr = ^acc_addr;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .en     (arr_en),
        .we     (acc_we),
        .idx    (acc_addr[IDX_W-1:0]),
        .wdata  (acc_wdata),
        .rdata  (arr_rdata)
    );

    // The storage read register has no reset; rd_ok masks it to zero until a valid read lands
    assign rdata = rd_ok ? arr_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_ok   <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
            err     <= 1'b0;
`endif
        end else begin
            ack <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        busy    <= 1'b1;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (go_done) begin
                ack <= 1'b1;
                if (!acc_we) begin
                    rd_ok <= in_range;
                end
`ifdef DMEM_BOUNDS_CHECK_EN
                err <= !in_range;
`endif
            end
        end
    end

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs: four instances covering 0/1/3 wait states and a 16-word depth.
module tb_data_memory_hs;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] we;
    logic [3:0] ack;
    logic [3:0] busy;
    logic [7:0] addr  [4];
    logic [7:0] wdata [4];
    logic [7:0] rdata [4];
`ifdef DMEM_BOUNDS_CHECK_EN
    logic [3:0] err;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_hs #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]),
        .rdata(rdata[0]), .ack(ack[0]), .busy(busy[0])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .err(err[0])
`endif
    );

    data_memory_hs #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]),
        .rdata(rdata[1]), .ack(ack[1]), .busy(busy[1])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .err(err[1])
`endif
    );

    data_memory_hs #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .we(we[2]), .addr(addr[2]), .wdata(wdata[2]),
        .rdata(rdata[2]), .ack(ack[2]), .busy(busy[2])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .err(err[2])
`endif
    );

    data_memory_hs #(.DATA_W(8), .ADDR_W(8), .DEPTH(16), .WAIT_STATES(0)) u_d16 (
        .clk(clk), .rst_n(rst_n), .req(req[3]), .we(we[3]), .addr(addr[3]), .wdata(wdata[3]),
        .rdata(rdata[3]), .ack(ack[3]), .busy(busy[3])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .err(err[3])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One handshake: returns edges from accept to ack, busy-high samples, ack one cycle later, err at ack
    task automatic run_txn(input int d, input logic w, input logic [7:0] a, input logic [7:0] wd,
                           output int lat, output int bcnt, output logic ack_after, output logic er);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        @(posedge clk); #1;
        req[d] = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!ack[d] && lat < 40) begin
            if (busy[d]) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy[d]) bcnt++;
`ifdef DMEM_BOUNDS_CHECK_EN
        er = err[d];
`else
        er = 1'b0;
`endif
        @(posedge clk); #1;
        ack_after = ack[d];
        if (busy[d]) bcnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         lat;
        int         bcnt;
        int         nack;
        int         alat;
        int         t;
        int         ack_cyc [3];
        logic       aa;
        logic       er;
        logic [7:0] rd;

        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        for (int i = 0; i < 4; i++) begin
            addr[i]  = '0;
            wdata[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_rdata0", 32'(rdata[0]), 32'h0);
        check("reset_rdata3", 32'(rdata[3]), 32'h0);
`ifdef DMEM_BOUNDS_CHECK_EN
        check("reset_err", 32'(err), 32'h0);
`endif
        rst_n = 1'b1;

        // zero wait states: write then read back
        run_txn(0, 1'b1, 8'h10, 8'hA5, lat, bcnt, aa, er);
        check("ws0_wr_lat", 32'(lat), 32'd1);
        check("ws0_wr_busy", 32'(bcnt), 32'd1);
        check("ws0_wr_ack_pulse", 32'(aa), 32'd0);
        check("ws0_wr_rdata_hold", 32'(rdata[0]), 32'h00);
        run_txn(0, 1'b0, 8'h10, 8'h00, lat, bcnt, aa, er);
        check("ws0_rd_lat", 32'(lat), 32'd1);
        check("ws0_rd_data", 32'(rdata[0]), 32'hA5);
        check("ws0_rd_ack_pulse", 32'(aa), 32'd0);
        run_txn(0, 1'b1, 8'h11, 8'h3C, lat, bcnt, aa, er);
        check("ws0_wr2_rdata_hold", 32'(rdata[0]), 32'hA5);

        // three wait states: preload, then read while req toggles during busy
        run_txn(1, 1'b1, 8'h02, 8'h3C, lat, bcnt, aa, er);
        check("ws3_wr_lat", 32'(lat), 32'd4);
        check("ws3_wr_busy", 32'(bcnt), 32'd4);
        run_txn(1, 1'b1, 8'h05, 8'h5A, lat, bcnt, aa, er);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 8'h02;
        @(posedge clk); #1;
        req[1] = 1'b0;
        nack = 0;
        alat = 0;
        rd   = '0;
        for (int i = 1; i <= 10; i++) begin
            if (ack[1]) begin
                nack++;
                alat = i;
                rd   = rdata[1];
            end
            @(negedge clk);
            if (i == 1 || i == 3) begin
                req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h05; wdata[1] = 8'hEE;
            end else begin
                req[1] = 1'b0;
            end
            @(posedge clk); #1;
        end
        check("ws3_rd_ack_count", 32'(nack), 32'd1);
        check("ws3_rd_lat", 32'(alat), 32'd4);
        check("ws3_rd_data", 32'(rd), 32'h3C);
        run_txn(1, 1'b0, 8'h05, 8'h00, lat, bcnt, aa, er);
        check("ws3_ignored_write", 32'(rdata[1]), 32'h5A);

        // one wait state, req held high across three back-to-back reads
        run_txn(2, 1'b1, 8'h40, 8'hC1, lat, bcnt, aa, er);
        run_txn(2, 1'b1, 8'h41, 8'hC2, lat, bcnt, aa, er);
        run_txn(2, 1'b1, 8'h42, 8'hC3, lat, bcnt, aa, er);
        check("ws1_wr_lat", 32'(lat), 32'd2);
        @(negedge clk);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 8'h40;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            @(posedge clk); #1;
            t++;
            while (!ack[2] && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            ack_cyc[k] = cyc;
            check($sformatf("ws1_stream_data%0d", k), 32'(rdata[2]), 32'hC1 + 32'(k));
            addr[2] = 8'h41 + 8'(k);
        end
        req[2] = 1'b0;
        check("ws1_stream_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
        check("ws1_stream_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
        repeat (3) @(posedge clk);
        #1;
        check("ws1_stream_idle", 32'(busy[2]), 32'd0);

        // reset while a write sits in WAIT
        run_txn(1, 1'b1, 8'h20, 8'h11, lat, bcnt, aa, er);
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h20; wdata[1] = 8'hFF;
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ack", 32'(ack), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_rdata1", 32'(rdata[1]), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack[1]) nack++;
        end
        check("rst_mid_no_ack", 32'(nack), 32'd0);
        run_txn(1, 1'b0, 8'h20, 8'h00, lat, bcnt, aa, er);
        check("rst_mid_not_committed", 32'(rdata[1]), 32'h11);

        // 16-word instance: out-of-range address handling
`ifdef DMEM_BOUNDS_CHECK_EN
        run_txn(3, 1'b1, 8'h03, 8'h55, lat, bcnt, aa, er);
        check("d16_inrange_wr_err", 32'(er), 32'd0);
        run_txn(3, 1'b1, 8'h13, 8'h77, lat, bcnt, aa, er);
        check("d16_oor_wr_lat", 32'(lat), 32'd1);
        check("d16_oor_wr_err", 32'(er), 32'd1);
        run_txn(3, 1'b0, 8'h03, 8'h00, lat, bcnt, aa, er);
        check("d16_oor_wr_no_alias", 32'(rdata[3]), 32'h55);
        check("d16_inrange_rd_err", 32'(er), 32'd0);
        run_txn(3, 1'b0, 8'h13, 8'h00, lat, bcnt, aa, er);
        check("d16_oor_rd_lat", 32'(lat), 32'd1);
        check("d16_oor_rd_err", 32'(er), 32'd1);
        check("d16_oor_rd_data", 32'(rdata[3]), 32'h00);
        check("d16_oor_err_pulse", 32'(err[3]), 32'd0);
`else
        run_txn(3, 1'b1, 8'h13, 8'h77, lat, bcnt, aa, er);
        check("d16_wrap_wr_lat", 32'(lat), 32'd1);
        run_txn(3, 1'b0, 8'h03, 8'h00, lat, bcnt, aa, er);
        check("d16_wrap_rd_data", 32'(rdata[3]), 32'h77);
        run_txn(3, 1'b1, 8'h0F, 8'h9E, lat, bcnt, aa, er);
        run_txn(3, 1'b0, 8'hFF, 8'h00, lat, bcnt, aa, er);
        check("d16_wrap_top_data", 32'(rdata[3]), 32'h9E);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
